// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack sequencer: token opcodes, error codes
// and the controller FSM states.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH   = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_XOR    = 3'd5;
  localparam logic [2:0] OP_MUL    = 3'd6;
  localparam logic [2:0] OP_RESULT = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_PUSH_OP = 4'd1,
    S_POP_B   = 4'd2,
    S_POP_A   = 4'd3,
    S_CAPT_A  = 4'd4,
    S_PUSH_R  = 4'd5,
    S_POP_R   = 4'd6,
    S_CAPT_R  = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  function automatic logic is_binary_op(input logic [2:0] op);
    return (op != OP_PUSH) && (op != OP_RESULT);
  endfunction

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Bundle of the token channel, the Stack push/pop port and the status outputs
// of one rpn_stack_ctrl instance.
interface rpn_stack_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
);

  // Token handshake: a token transfers on a rising edge where tok_valid and
  // tok_ready are both high; tok_op/tok_data are only meaningful then and may
  // change freely while tok_ready is low.
  logic             tok_valid;
  logic             tok_ready;
  logic [2:0]       tok_op;
  logic [WIDTH-1:0] tok_data;
  logic             err_clr;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             stack_full;
  logic             stack_empty;

  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] depth;

  // Controller side.
  modport slave (
    input  tok_valid, tok_op, tok_data, err_clr,
    input  data_out, stack_full, stack_empty,
    output tok_ready, push, pop, data_in,
    output result, result_valid, err, err_code, depth
  );

  // Environment side: token source plus the attached Stack.
  modport master (
    output tok_valid, tok_op, tok_data, err_clr,
    output data_out, stack_full, stack_empty,
    input  tok_ready, push, pop, data_in,
    input  result, result_valid, err, err_code, depth
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational operator unit: b is the former top of stack, a the entry
// below it. All results wrap modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MUL:  y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish sequencer: turns a token stream into push/pop commands for an
// attached Stack, tracking occupancy locally and flagging under/overflow.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  rpn_stack_ctrl_if.slave bus,
  output state_t         dbg_state
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] alu_y;
  logic             unused_stack_empty;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      depth_q        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      opnd_q         <= '0;
      op_q           <= OP_PUSH;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      depth_q        <= depth_d;
      a_q            <= a_d;
      b_q            <= b_d;
      opnd_q         <= opnd_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_code_q     <= err_code_d;
    end
  end

  // The Stack presents a popped value one cycle after pop, so each capture
  // happens in the state following the pop that produced it.
  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    a_d            = a_q;
    b_d            = b_q;
    opnd_d         = opnd_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_code_d     = err_code_q;
    push           = 1'b0;
    pop            = 1'b0;
    data_in        = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.tok_valid) begin
          if (bus.tok_op == OP_PUSH) begin
            if (depth_q == DEPTH_C || bus.stack_full) begin
              state_d    = S_ERR;
              err_code_d = ERR_OVER;
            end else begin
              opnd_d  = bus.tok_data;
              state_d = S_PUSH_OP;
            end
          end else if (bus.tok_op == OP_RESULT) begin
            if (depth_q == '0) begin
              state_d    = S_ERR;
              err_code_d = ERR_UNDER;
            end else begin
              state_d = S_POP_R;
            end
          end else if (is_binary_op(bus.tok_op)) begin
            if (depth_q < TWO_C) begin
              state_d    = S_ERR;
              err_code_d = ERR_UNDER;
            end else begin
              op_d    = bus.tok_op;
              state_d = S_POP_B;
            end
          end
        end
      end
      S_PUSH_OP: begin
        push    = 1'b1;
        data_in = opnd_q;
        depth_d = depth_q + ONE_C;
        state_d = S_IDLE;
      end
      S_POP_B: begin
        pop     = 1'b1;
        depth_d = depth_q - ONE_C;
        state_d = S_POP_A;
      end
      S_POP_A: begin
        pop     = 1'b1;
        depth_d = depth_q - ONE_C;
        b_d     = bus.data_out;
        state_d = S_CAPT_A;
      end
      S_CAPT_A: begin
        a_d     = bus.data_out;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        push    = 1'b1;
        data_in = alu_y;
        depth_d = depth_q + ONE_C;
        state_d = S_IDLE;
      end
      S_POP_R: begin
        pop     = 1'b1;
        depth_d = depth_q - ONE_C;
        state_d = S_CAPT_R;
      end
      S_CAPT_R: begin
        // result and its strobe are registered together so they line up.
        result_d       = bus.data_out;
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      S_ERR: begin
        if (bus.err_clr) begin
          err_code_d = ERR_NONE;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tok_ready    = (state_q == S_IDLE);
  assign bus.push         = push;
  assign bus.pop          = pop;
  assign bus.data_in      = data_in;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err          = (state_q == S_ERR);
  assign bus.err_code     = err_code_q;
  assign bus.depth        = depth_q;
  assign dbg_state        = state_q;

  assign unused_stack_empty = bus.stack_empty;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural 8x8 Stack attached to
// its push/pop port.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  int checks;
  int failures;

  rpn_stack_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stack model ----------------
  logic [WIDTH-1:0] stk_mem [DEPTH];
  logic [WIDTH-1:0] stk_dout;
  int               stk_sp;
  string            ev_str;
  int               both_cnt;
  int               rv_count;
  logic [WIDTH-1:0] last_result;

  assign bus.data_out    = stk_dout;
  assign bus.stack_full  = (stk_sp == DEPTH);
  assign bus.stack_empty = (stk_sp == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_sp   <= 0;
      stk_dout <= '0;
    end else begin
      if (bus.push && stk_sp < DEPTH) begin
        stk_mem[stk_sp] <= bus.data_in;
        stk_sp          <= stk_sp + 1;
      end else if (bus.pop && stk_sp > 0) begin
        stk_dout <= stk_mem[stk_sp-1];
        stk_sp   <= stk_sp - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.push) ev_str = {ev_str, "P"};
      if (bus.pop)  ev_str = {ev_str, "O"};
      if (bus.push && bus.pop) both_cnt++;
      if (bus.result_valid) begin
        rv_count++;
        last_result = bus.result;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_token(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int n;
    bus.tok_op    = op;
    bus.tok_data  = data;
    bus.tok_valid = 1'b1;
    n = 0;
    while (!bus.tok_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.tok_ready) begin
      failures++;
      $display("FAIL send_token_timeout op=%0d tok_ready=%0b required=1", op, bus.tok_ready);
    end else begin
      @(posedge clk); #1;
    end
    checks++;
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.tok_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.tok_ready) begin
      failures++;
      $display("FAIL wait_ready_timeout tok_ready=%0b required=1", bus.tok_ready);
    end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #12;
    if (bus.tok_ready !== 1'b1) begin failures++; $display("FAIL rst_tok_ready got=%0b exp=1", bus.tok_ready); end
    checks++;
    if (bus.push !== 1'b0 || bus.pop !== 1'b0) begin failures++; $display("FAIL rst_push_pop got=%0b%0b exp=00", bus.push, bus.pop); end
    checks++;
    if (bus.data_in !== 8'h00) begin failures++; $display("FAIL rst_data_in got=%h exp=00", bus.data_in); end
    checks++;
    if (bus.result !== 8'h00 || bus.result_valid !== 1'b0) begin failures++; $display("FAIL rst_result got=%h/%0b exp=00/0", bus.result, bus.result_valid); end
    checks++;
    if (bus.err !== 1'b0 || bus.err_code !== 2'd0) begin failures++; $display("FAIL rst_err got=%0b/%0d exp=0/0", bus.err, bus.err_code); end
    checks++;
    if (bus.depth !== 4'd0) begin failures++; $display("FAIL rst_depth got=%0d exp=0", bus.depth); end
    checks++;
    if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    ev_str = ""; rv_count = 0;
    send_token(OP_PUSH, 8'd3);
    send_token(OP_PUSH, 8'd4);
    send_token(OP_ADD, 8'd0);
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'd7) begin failures++; $display("FAIL add_result got=%h exp=07", last_result); end
    checks++;
    if (rv_count != 1) begin failures++; $display("FAIL add_rv_pulses got=%0d exp=1", rv_count); end
    checks++;
    if (ev_str != "PPOOPO") begin failures++; $display("FAIL add_stack_seq got=%s exp=PPOOPO", ev_str); end
    checks++;
    if (bus.depth !== 4'd0) begin failures++; $display("FAIL add_depth got=%0d exp=0", bus.depth); end
    checks++;
  endtask

  task automatic test_sub_mul();
    rv_count = 0;
    send_token(OP_PUSH, 8'd2);
    send_token(OP_PUSH, 8'd5);
    send_token(OP_SUB, 8'd0);
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'hFD) begin failures++; $display("FAIL sub_wrap got=%h exp=fd", last_result); end
    checks++;
    send_token(OP_PUSH, 8'd20);
    send_token(OP_PUSH, 8'd13);
    send_token(OP_MUL, 8'd0);
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'h04) begin failures++; $display("FAIL mul_low got=%h exp=04", last_result); end
    checks++;
    if (rv_count != 2) begin failures++; $display("FAIL sub_mul_pulses got=%0d exp=2", rv_count); end
    checks++;
  endtask

  task automatic test_logic();
    send_token(OP_PUSH, 8'hC3);
    send_token(OP_PUSH, 8'h5A);
    send_token(OP_AND, 8'd0);
    send_token(OP_PUSH, 8'h0F);
    send_token(OP_OR, 8'd0);
    send_token(OP_PUSH, 8'hFF);
    send_token(OP_XOR, 8'd0);
    wait_ready();
    if (bus.depth !== 4'd1) begin failures++; $display("FAIL logic_depth got=%0d exp=1", bus.depth); end
    checks++;
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'hB0) begin failures++; $display("FAIL logic_result got=%h exp=b0", last_result); end
    checks++;
  endtask

  task automatic test_underflow();
    ev_str = "";
    send_token(OP_PUSH, 8'd1);
    send_token(OP_ADD, 8'd0);
    repeat (2) begin @(posedge clk); #1; end
    if (bus.err !== 1'b1 || bus.err_code !== ERR_UNDER) begin failures++; $display("FAIL under_err got=%0b/%0d exp=1/1", bus.err, bus.err_code); end
    checks++;
    if (ev_str != "P") begin failures++; $display("FAIL under_no_pop got=%s exp=P", ev_str); end
    checks++;
    if (bus.depth !== 4'd1) begin failures++; $display("FAIL under_depth got=%0d exp=1", bus.depth); end
    checks++;
    if (bus.tok_ready !== 1'b0) begin failures++; $display("FAIL under_ready got=%0b exp=0", bus.tok_ready); end
    checks++;
    pulse_err_clr();
    if (bus.tok_ready !== 1'b1 || bus.err !== 1'b0 || bus.err_code !== ERR_NONE) begin
      failures++; $display("FAIL under_clr got=%0b/%0b/%0d exp=1/0/0", bus.tok_ready, bus.err, bus.err_code);
    end
    checks++;
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'd1) begin failures++; $display("FAIL under_result got=%h exp=01", last_result); end
    checks++;
    pulse_err_clr();
    if (bus.err !== 1'b0 || bus.tok_ready !== 1'b1) begin failures++; $display("FAIL clr_outside_err got=%0b/%0b exp=0/1", bus.err, bus.tok_ready); end
    checks++;
  endtask

  task automatic test_overflow();
    ev_str = "";
    for (int i = 0; i < DEPTH; i++) send_token(OP_PUSH, 8'(10 + i));
    send_token(OP_PUSH, 8'd99);
    repeat (2) begin @(posedge clk); #1; end
    if (bus.err !== 1'b1 || bus.err_code !== ERR_OVER) begin failures++; $display("FAIL over_err got=%0b/%0d exp=1/2", bus.err, bus.err_code); end
    checks++;
    if (ev_str != "PPPPPPPP") begin failures++; $display("FAIL over_no_push got=%s exp=PPPPPPPP", ev_str); end
    checks++;
    if (bus.depth !== 4'd8 || bus.stack_full !== 1'b1) begin failures++; $display("FAIL over_depth got=%0d/%0b exp=8/1", bus.depth, bus.stack_full); end
    checks++;
    pulse_err_clr();
    send_token(OP_RESULT, 8'd0);
    wait_ready();
    if (last_result !== 8'd17) begin failures++; $display("FAIL over_result got=%h exp=11", last_result); end
    checks++;
    if (bus.depth !== 4'd7) begin failures++; $display("FAIL over_depth_after got=%0d exp=7", bus.depth); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n;
    send_token(OP_ADD, 8'd0);
    n = 0;
    while (dbg_state !== S_POP_A && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (dbg_state !== S_POP_A) begin failures++; $display("FAIL rmid_reach_pop_a got=%0d exp=%0d", dbg_state, S_POP_A); end
    checks++;
    #2;
    reset = 1'b1;
    #1;
    if (bus.pop !== 1'b0 || bus.push !== 1'b0 || bus.data_in !== 8'h00) begin
      failures++; $display("FAIL rmid_port got=%0b/%0b/%h exp=0/0/00", bus.pop, bus.push, bus.data_in);
    end
    checks++;
    if (bus.depth !== 4'd0 || bus.result !== 8'h00 || bus.err !== 1'b0 || bus.err_code !== 2'd0) begin
      failures++; $display("FAIL rmid_status got=%0d/%h/%0b/%0d exp=0/00/0/0", bus.depth, bus.result, bus.err, bus.err_code);
    end
    checks++;
    if (bus.tok_ready !== 1'b1 || dbg_state !== S_IDLE) begin failures++; $display("FAIL rmid_state got=%0b/%0d exp=1/0", bus.tok_ready, dbg_state); end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    if (bus.tok_ready !== 1'b1 || bus.stack_empty !== 1'b1) begin failures++; $display("FAIL rmid_after got=%0b/%0b exp=1/1", bus.tok_ready, bus.stack_empty); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]       op_v  [6];
    logic [WIDTH-1:0] dat_v [6];
    int               exp_acc [6];
    int               acc_q[$];
    int               idx;
    logic             rdy;
    op_v  = '{OP_PUSH, OP_PUSH, OP_MUL, OP_PUSH, OP_SUB, OP_RESULT};
    dat_v = '{8'd6, 8'd7, 8'd0, 8'd2, 8'd0, 8'd0};
    exp_acc = '{0, 2, 4, 9, 11, 16};
    rv_count = 0;
    idx = 0;
    bus.tok_op    = op_v[0];
    bus.tok_data  = dat_v[0];
    bus.tok_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      rdy = bus.tok_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc_q.push_back(c);
        idx++;
        if (idx < 6) begin
          bus.tok_op   = op_v[idx];
          bus.tok_data = dat_v[idx];
        end else begin
          bus.tok_valid = 1'b0;
        end
      end
    end
    bus.tok_valid = 1'b0;
    if (acc_q.size() != 6) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=6", acc_q.size()); end
    checks++;
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      if (acc_q[i] != exp_acc[i]) begin failures++; $display("FAIL b2b_accept_cycle[%0d] got=%0d exp=%0d", i, acc_q[i], exp_acc[i]); end
      checks++;
    end
    wait_ready();
    if (last_result !== 8'h28 || rv_count != 1) begin failures++; $display("FAIL b2b_result got=%h/%0d exp=28/1", last_result, rv_count); end
    checks++;
    if (bus.err !== 1'b0 || bus.depth !== 4'd0) begin failures++; $display("FAIL b2b_status got=%0b/%0d exp=0/0", bus.err, bus.depth); end
    checks++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    both_cnt = 0; rv_count = 0; last_result = '0; ev_str = "";
    bus.tok_valid = 1'b0;
    bus.tok_op    = OP_PUSH;
    bus.tok_data  = '0;
    bus.err_clr   = 1'b0;
    test_reset();
    test_add();
    test_sub_mul();
    test_logic();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    if (both_cnt != 0) begin failures++; $display("FAIL push_pop_overlap got=%0d exp=0", both_cnt); end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
